cursor_controller: RTL and testbench
====================================

// Module: cursor_controller
// PURPOSE
//  Sequences the terminal cursor. Accepts movement commands from the escape/keyboard
//  decoder and computes the next position with clamping, tabs and wrap. Drives the
//  new_cursor_x/new_cursor_y/write_cursor_pos inputs of the cursor_position registers.
//  Requests a screen scroll from the video memory controller on LF past the last row.
// PARAMETERS
//  XW        6   cursor column width (bits)
//  YW        4   cursor row width (bits)
//  LAST_COL  63  highest legal column
//  LAST_ROW  15  highest legal row
// PORTS
//  px_clk            in   1   pixel clock; only clock
//  clr               in   1   reset, synchronous, active-high
//  cmd_valid         in   1   command present
//  cmd_ready         out  1   controller idle; command accepted when valid&ready
//  cmd               in   4   opcode (see BEHAVIOUR)
//  cmd_x             in   XW  SET column operand
//  cmd_y             in   YW  SET row operand
//  new_cursor_x      out  XW  position to load into X register
//  new_cursor_y      out  YW  position to load into Y register
//  write_cursor_pos  out  1   one-cycle load strobe
//  scroll_req        out  1   scroll request; held until acknowledged
//  scroll_dir        out  1   1 = scroll up (LF), 0 = scroll down (RLF)
//  scroll_ack        in   1   scroll done
// BEHAVIOUR
//  - Reset: state IDLE; new_cursor_x=0, new_cursor_y=0, write_cursor_pos=0,
//    scroll_req=0, scroll_dir=0, cmd_ready=1 the cycle after clr deasserts.
//  - All outputs are registered. Internal position (x,y) is held in new_cursor_x/y.
//  - States: IDLE -> (accept) WRITE | SCROLL; SCROLL -> (scroll_ack) WRITE; WRITE -> IDLE.
//  - cmd_ready=1 only in IDLE. Accept at edge N: next position loaded at N;
//    write_cursor_pos=1 for exactly the cycle after N (WRITE state); ready again N+2.
//  - Opcodes: 0 NOP (accepted, no strobe, stays IDLE); 1 UP y-1, clamp at 0;
//    2 DOWN y+1, clamp at LAST_ROW (no scroll); 3 RIGHT x+1, clamp at LAST_COL;
//    4 LEFT/BS x-1, clamp at 0; 5 HOME x=0,y=0; 6 CR x=0;
//    7 LF y+1; at LAST_ROW -> SCROLL, dir=1, y unchanged;
//    8 RLF y-1; at row 0 -> SCROLL, dir=0, y unchanged;
//    9 TAB x=min((x|7)+1, LAST_COL); A SET x=min(cmd_x,LAST_COL), y=min(cmd_y,LAST_ROW);
//    B ADVANCE (post-character) x+1, at LAST_COL see CONFIGURATION; C-F treated as NOP.
//  - SCROLL: scroll_req=1, scroll_dir stable, from cycle after accept until the
//    cycle scroll_ack is sampled 1; scroll_req drops with entry to WRITE.
//    scroll_ack outside SCROLL is ignored.
//  - cmd_valid outside IDLE is not accepted; operands must stay stable until accepted.
//  - clr at any time (incl. mid-SCROLL) returns to reset values next edge; a pending
//    scroll request is abandoned, no strobe emitted.
//  - Arithmetic in XW/YW bits; clamping precedes any wrap (no modulo overflow).
// CONFIGURATION
//  CURSOR_AUTOWRAP_EN defined: ADVANCE at LAST_COL -> x=0 plus LF semantics
//    (y+1, or SCROLL dir=1 with y unchanged at LAST_ROW).
//  Not defined: ADVANCE at LAST_COL leaves x=LAST_COL, y unchanged, strobe still issued.
// TESTING
//  1 clr 2 cycles, release -> all outputs 0, cmd_ready=1; scroll_req stays 0.
//  2 SET(70,20) -> new_cursor_x=63, new_cursor_y=15, strobe 1 cycle after accept;
//    then RIGHT -> x=63; then DOWN -> y=15, scroll_req=0.
//  3 at (5,15) LF -> scroll_req=1 dir=1; ack after 4 cycles -> scroll_req drops,
//    strobe next cycle with (5,15); cmd_ready low throughout until WRITE done.
//  4 at (10,0) RLF -> scroll_req dir=0; clr asserted mid-SCROLL -> reset values,
//    no strobe; ack afterwards ignored.
//  5 TAB from x=0 -> 8, from 8 -> 16, from 60 -> 63; CR -> x=0; HOME -> (0,0);
//    LEFT at 0 -> 0; NOP and opcode E -> accepted, no strobe.
//  6 at (63,3) ADVANCE -> with CURSOR_AUTOWRAP_EN (0,4); without (63,3);
//    at (63,15) with macro -> scroll_req dir=1, final (0,15).

Source files
------------

// File: rtl/cursor_controller.sv
// Terminal cursor sequencer: turns decoder movement commands into clamped positions,
// load strobes and scroll requests. Optional macro CURSOR_AUTOWRAP_EN enables ADVANCE wrap.
module cursor_controller #(
    parameter int XW       = 6,
    parameter int YW       = 4,
    parameter int LAST_COL = 63,
    parameter int LAST_ROW = 15
) (
    input  logic          px_clk,
    input  logic          clr,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd,
    input  logic [XW-1:0] cmd_x,
    input  logic [YW-1:0] cmd_y,
    output logic [XW-1:0] new_cursor_x,
    output logic [YW-1:0] new_cursor_y,
    output logic          write_cursor_pos,
    output logic          scroll_req,
    output logic          scroll_dir,
    input  logic          scroll_ack
);

    localparam logic [XW-1:0] LAST_X  = XW'(LAST_COL);
    localparam logic [YW-1:0] LAST_Y  = YW'(LAST_ROW);
    localparam logic [XW-1:0] ONE_X   = XW'(1);
    localparam logic [YW-1:0] ONE_Y   = YW'(1);
    localparam logic [XW-1:0] TAB_MSK = XW'(7);
    localparam logic [XW:0]   ONE_XW1 = (XW+1)'(1);

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_UP    = 4'h1;
    localparam logic [3:0] OP_DOWN  = 4'h2;
    localparam logic [3:0] OP_RIGHT = 4'h3;
    localparam logic [3:0] OP_LEFT  = 4'h4;
    localparam logic [3:0] OP_HOME  = 4'h5;
    localparam logic [3:0] OP_CR    = 4'h6;
    localparam logic [3:0] OP_LF    = 4'h7;
    localparam logic [3:0] OP_RLF   = 4'h8;
    localparam logic [3:0] OP_TAB   = 4'h9;
    localparam logic [3:0] OP_SET   = 4'hA;
    localparam logic [3:0] OP_ADV   = 4'hB;

    typedef enum logic [1:0] {IDLE, WRITE, SCROLL} state_t;

    state_t        state, next_state;
    logic [XW-1:0] next_x;
    logic [YW-1:0] next_y;
    logic          next_write, next_req, next_dir, next_ready;
    logic          do_write, do_scroll, scroll_up;
    logic [XW:0]   tab_sum;

    // Registered outputs double as the held cursor position.
    always_ff @(posedge px_clk) begin
        if (clr) begin
            state            <= IDLE;
            new_cursor_x     <= '0;
            new_cursor_y     <= '0;
            write_cursor_pos <= 1'b0;
            scroll_req       <= 1'b0;
            scroll_dir       <= 1'b0;
            cmd_ready        <= 1'b1;
        end else begin
            state            <= next_state;
            new_cursor_x     <= next_x;
            new_cursor_y     <= next_y;
            write_cursor_pos <= next_write;
            scroll_req       <= next_req;
            scroll_dir       <= next_dir;
            cmd_ready        <= next_ready;
        end
    end

    always_comb begin
        next_state = state;
        next_x     = new_cursor_x;
        next_y     = new_cursor_y;
        next_write = 1'b0;
        next_req   = scroll_req;
        next_dir   = scroll_dir;
        next_ready = 1'b0;
        do_write   = 1'b0;
        do_scroll  = 1'b0;
        scroll_up  = 1'b0;
        // Widened so that (x|7)+1 at the last tab stop cannot wrap before clamping.
        tab_sum    = {1'b0, new_cursor_x | TAB_MSK} + ONE_XW1;

        case (state)
            IDLE: begin
                next_ready = 1'b1;
                if (cmd_valid) begin
                    do_write = 1'b1;
                    case (cmd)
                        OP_NOP: do_write = 1'b0;
                        OP_UP: begin
                            if (new_cursor_y != '0) next_y = new_cursor_y - ONE_Y;
                        end
                        OP_DOWN: begin
                            if (new_cursor_y != LAST_Y) next_y = new_cursor_y + ONE_Y;
                        end
                        OP_RIGHT: begin
                            if (new_cursor_x != LAST_X) next_x = new_cursor_x + ONE_X;
                        end
                        OP_LEFT: begin
                            if (new_cursor_x != '0) next_x = new_cursor_x - ONE_X;
                        end
                        OP_HOME: begin
                            next_x = '0;
                            next_y = '0;
                        end
                        OP_CR: next_x = '0;
                        OP_LF: begin
                            if (new_cursor_y == LAST_Y) begin
                                do_scroll = 1'b1;
                                scroll_up = 1'b1;
                            end else begin
                                next_y = new_cursor_y + ONE_Y;
                            end
                        end
                        OP_RLF: begin
                            if (new_cursor_y == '0) do_scroll = 1'b1;
                            else                    next_y = new_cursor_y - ONE_Y;
                        end
                        OP_TAB: begin
                            if (tab_sum > {1'b0, LAST_X}) next_x = LAST_X;
                            else                          next_x = tab_sum[XW-1:0];
                        end
                        OP_SET: begin
                            next_x = (cmd_x > LAST_X) ? LAST_X : cmd_x;
                            next_y = (cmd_y > LAST_Y) ? LAST_Y : cmd_y;
                        end
                        OP_ADV: begin
                            if (new_cursor_x != LAST_X) begin
                                next_x = new_cursor_x + ONE_X;
                            end else begin
`ifdef CURSOR_AUTOWRAP_EN
                                next_x = '0;
                                if (new_cursor_y == LAST_Y) begin
                                    do_scroll = 1'b1;
                                    scroll_up = 1'b1;
                                end else begin
                                    next_y = new_cursor_y + ONE_Y;
                                end
`else
                                next_x = LAST_X;
`endif
                            end
                        end
                        default: do_write = 1'b0;
                    endcase

                    if (do_scroll) begin
                        next_state = SCROLL;
                        next_req   = 1'b1;
                        next_dir   = scroll_up;
                        next_ready = 1'b0;
                    end else if (do_write) begin
                        next_state = WRITE;
                        next_write = 1'b1;
                        next_ready = 1'b0;
                    end
                end
            end
            WRITE: begin
                next_state = IDLE;
                next_ready = 1'b1;
            end
            SCROLL: begin
                if (scroll_ack) begin
                    next_state = WRITE;
                    next_req   = 1'b0;
                    next_write = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cursor_controller.sv
// Self-checking bench for cursor_controller: table of single commands with expected
// positions, plus directed scroll, reset-abort and ADVANCE wrap sequences.
module tb_cursor_controller;

    localparam int XW = 7;
    localparam int YW = 5;

    logic          px_clk = 1'b0;
    logic          clr = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [3:0]    cmd = 4'h0;
    logic [XW-1:0] cmd_x = '0;
    logic [YW-1:0] cmd_y = '0;
    logic [XW-1:0] new_cursor_x;
    logic [YW-1:0] new_cursor_y;
    logic          write_cursor_pos;
    logic          scroll_req;
    logic          scroll_dir;
    logic          scroll_ack = 1'b0;

    int checks = 0;
    int fails  = 0;

    cursor_controller #(.XW(XW), .YW(YW), .LAST_COL(63), .LAST_ROW(15)) dut (
        .px_clk(px_clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd(cmd), .cmd_x(cmd_x), .cmd_y(cmd_y),
        .new_cursor_x(new_cursor_x), .new_cursor_y(new_cursor_y),
        .write_cursor_pos(write_cursor_pos), .scroll_req(scroll_req),
        .scroll_dir(scroll_dir), .scroll_ack(scroll_ack)
    );

    always #5 px_clk = ~px_clk;

    typedef struct {
        logic [3:0]    op;
        logic [XW-1:0] ox;
        logic [YW-1:0] oy;
        logic [XW-1:0] ex;
        logic [YW-1:0] ey;
        logic          strobe;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic [3:0] op, input int ox, input int oy,
                          input int ex, input int ey, input logic strobe);
        vec_t v;
        v.op = op; v.ox = XW'(ox); v.oy = YW'(oy);
        v.ex = XW'(ex); v.ey = YW'(ey); v.strobe = strobe;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Presents one command at a negedge, waits for acceptance, returns at the next negedge.
    task automatic applyStimulus(input logic [3:0] op, input logic [XW-1:0] ox,
                                 input logic [YW-1:0] oy);
        int waited = 0;
        while (!cmd_ready && waited < 20) begin
            @(negedge px_clk);
            waited++;
        end
        if (!cmd_ready) checkOutput("ready_timeout", 0, 1);
        cmd = op; cmd_x = ox; cmd_y = oy; cmd_valid = 1'b1;
        @(posedge px_clk);
        @(negedge px_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic setPos(input int px, input int py);
        applyStimulus(4'hA, XW'(px), YW'(py));
        @(negedge px_clk);
    endtask

    task automatic checkScrollPhase(input string name, input logic dir,
                                    input int ex, input int ey);
        checkOutput({name, "_req"}, int'(scroll_req), 1);
        checkOutput({name, "_dir"}, int'(scroll_dir), int'(dir));
        checkOutput({name, "_nostrobe"}, int'(write_cursor_pos), 0);
        checkOutput({name, "_busy"}, int'(cmd_ready), 0);
        checkOutput({name, "_x"}, int'(new_cursor_x), ex);
        checkOutput({name, "_y"}, int'(new_cursor_y), ey);
    endtask

    initial begin
        addVec(4'hA, 70, 20, 63, 15, 1'b1);
        addVec(4'h3,  0,  0, 63, 15, 1'b1);
        addVec(4'h2,  0,  0, 63, 15, 1'b1);
        addVec(4'h1,  0,  0, 63, 14, 1'b1);
        addVec(4'h5,  0,  0,  0,  0, 1'b1);
        addVec(4'h1,  0,  0,  0,  0, 1'b1);
        addVec(4'h4,  0,  0,  0,  0, 1'b1);
        addVec(4'h9,  0,  0,  8,  0, 1'b1);
        addVec(4'h9,  0,  0, 16,  0, 1'b1);
        addVec(4'hA, 60,  2, 60,  2, 1'b1);
        addVec(4'h9,  0,  0, 63,  2, 1'b1);
        addVec(4'h6,  0,  0,  0,  2, 1'b1);
        addVec(4'h0,  0,  0,  0,  2, 1'b0);
        addVec(4'hE,  0,  0,  0,  2, 1'b0);
        addVec(4'h3,  0,  0,  1,  2, 1'b1);
        addVec(4'h2,  0,  0,  1,  3, 1'b1);
        addVec(4'h7,  0,  0,  1,  4, 1'b1);
        addVec(4'h8,  0,  0,  1,  3, 1'b1);
        addVec(4'hB,  0,  0,  2,  3, 1'b1);
        addVec(4'hA,  7, 31,  7, 15, 1'b1);
        addVec(4'h9,  0,  0,  8, 15, 1'b1);
        addVec(4'hA, 63,  3, 63,  3, 1'b1);
`ifdef CURSOR_AUTOWRAP_EN
        addVec(4'hB,  0,  0,  0,  4, 1'b1);
`else
        addVec(4'hB,  0,  0, 63,  3, 1'b1);
`endif

        repeat (2) @(posedge px_clk);
        @(negedge px_clk);
        clr = 1'b0;
        @(negedge px_clk);
        checkOutput("reset_x", int'(new_cursor_x), 0);
        checkOutput("reset_y", int'(new_cursor_y), 0);
        checkOutput("reset_strobe", int'(write_cursor_pos), 0);
        checkOutput("reset_req", int'(scroll_req), 0);
        checkOutput("reset_dir", int'(scroll_dir), 0);
        checkOutput("reset_ready", int'(cmd_ready), 1);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].ox, vecs[i].oy);
            checkOutput($sformatf("vec%0d_strobe", i), int'(write_cursor_pos), int'(vecs[i].strobe));
            checkOutput($sformatf("vec%0d_x", i), int'(new_cursor_x), int'(vecs[i].ex));
            checkOutput($sformatf("vec%0d_y", i), int'(new_cursor_y), int'(vecs[i].ey));
            checkOutput($sformatf("vec%0d_req", i), int'(scroll_req), 0);
            checkOutput($sformatf("vec%0d_ready", i), int'(cmd_ready), int'(!vecs[i].strobe));
            if (vecs[i].strobe) begin
                @(negedge px_clk);
                checkOutput($sformatf("vec%0d_strobe_end", i), int'(write_cursor_pos), 0);
                checkOutput($sformatf("vec%0d_ready_again", i), int'(cmd_ready), 1);
            end
        end

        // LF on the last row: scroll up, held for four cycles, then strobe after ack.
        setPos(5, 15);
        applyStimulus(4'h7, '0, '0);
        checkScrollPhase("lf_scroll", 1'b1, 5, 15);
        repeat (3) @(negedge px_clk);
        checkScrollPhase("lf_hold", 1'b1, 5, 15);
        scroll_ack = 1'b1;
        @(negedge px_clk);
        scroll_ack = 1'b0;
        checkOutput("lf_req_drop", int'(scroll_req), 0);
        checkOutput("lf_strobe", int'(write_cursor_pos), 1);
        checkOutput("lf_x", int'(new_cursor_x), 5);
        checkOutput("lf_y", int'(new_cursor_y), 15);
        checkOutput("lf_busy_write", int'(cmd_ready), 0);
        @(negedge px_clk);
        checkOutput("lf_strobe_end", int'(write_cursor_pos), 0);
        checkOutput("lf_ready", int'(cmd_ready), 1);

        // Stray ack while idle must change nothing.
        scroll_ack = 1'b1;
        repeat (2) @(negedge px_clk);
        scroll_ack = 1'b0;
        checkOutput("idle_ack_strobe", int'(write_cursor_pos), 0);
        checkOutput("idle_ack_req", int'(scroll_req), 0);
        checkOutput("idle_ack_ready", int'(cmd_ready), 1);

        // RLF on row 0 scrolls down; clr mid-scroll abandons it.
        setPos(10, 0);
        applyStimulus(4'h8, '0, '0);
        checkScrollPhase("rlf_scroll", 1'b0, 10, 0);
        @(negedge px_clk);
        clr = 1'b1;
        @(negedge px_clk);
        clr = 1'b0;
        checkOutput("abort_x", int'(new_cursor_x), 0);
        checkOutput("abort_y", int'(new_cursor_y), 0);
        checkOutput("abort_req", int'(scroll_req), 0);
        checkOutput("abort_dir", int'(scroll_dir), 0);
        checkOutput("abort_strobe", int'(write_cursor_pos), 0);
        checkOutput("abort_ready", int'(cmd_ready), 1);
        scroll_ack = 1'b1;
        repeat (2) begin
            @(negedge px_clk);
            checkOutput("abort_ack_strobe", int'(write_cursor_pos), 0);
            checkOutput("abort_ack_req", int'(scroll_req), 0);
        end
        scroll_ack = 1'b0;

        // ADVANCE at the bottom-right corner.
        setPos(63, 15);
        applyStimulus(4'hB, '0, '0);
`ifdef CURSOR_AUTOWRAP_EN
        checkScrollPhase("wrap_scroll", 1'b1, 0, 15);
        @(negedge px_clk);
        scroll_ack = 1'b1;
        @(negedge px_clk);
        scroll_ack = 1'b0;
        checkOutput("wrap_strobe", int'(write_cursor_pos), 1);
        checkOutput("wrap_req_drop", int'(scroll_req), 0);
        checkOutput("wrap_x", int'(new_cursor_x), 0);
        checkOutput("wrap_y", int'(new_cursor_y), 15);
`else
        checkOutput("adv_corner_strobe", int'(write_cursor_pos), 1);
        checkOutput("adv_corner_req", int'(scroll_req), 0);
        checkOutput("adv_corner_x", int'(new_cursor_x), 63);
        checkOutput("adv_corner_y", int'(new_cursor_y), 15);
`endif
        @(negedge px_clk);
        checkOutput("final_ready", int'(cmd_ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
